// File: rtl/cmp_scheduler.sv
// Round-robin sequencer that shares one external 32-bit ripple comparator between
// the branch unit (port 0) and the ALU SLT/SLTU path (port 1).
module cmp_scheduler (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic [2:0]  req0_op,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic [2:0]  req1_op,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic        resp_result,
    output logic        resp_id,
    output logic        resp_err,
    output logic [31:0] cmp_m,
    output logic [31:0] cmp_n,
    output logic        cmp_equal,
    input  logic        cmp_result
);

    typedef enum logic [1:0] {IDLE, PASS1, PASS2, DONE} state_t;

    state_t      state, state_next;
    logic        pri;
    logic        grant0, grant1, accept, sel_id;
    logic [31:0] sel_a, sel_b, xa, xb;
    logic [2:0]  sel_op;
    logic        sel_legal, sel_signed;
    logic        single_q, pol_q, p1_q;

    // Arbitration and operand selection; pri set means port 1 holds priority.
    always_comb begin
        grant0     = req0_valid && (!req1_valid || !pri);
        grant1     = req1_valid && !grant0;
        req0_ready = (state == IDLE) && !rst && grant0;
        req1_ready = (state == IDLE) && !rst && grant1;
        accept     = req0_ready || req1_ready;
        sel_id     = grant1;
        sel_a      = sel_id ? req1_a  : req0_a;
        sel_b      = sel_id ? req1_b  : req0_b;
        sel_op     = sel_id ? req1_op : req0_op;
        sel_legal  = (sel_op[2:1] != 2'b01);
        sel_signed = (sel_op[2:1] == 2'b10);
        // Flipping the sign bit turns a signed order into an unsigned one.
        xa         = {sel_a[31] ^ sel_signed, sel_a[30:0]};
        xb         = {sel_b[31] ^ sel_signed, sel_b[30:0]};
    end

    always_comb begin
        state_next = state;
        resp_valid = 1'b0;
        case (state)
            IDLE:  if (accept) state_next = sel_legal ? PASS1 : DONE;
            PASS1: state_next = single_q ? DONE : PASS2;
            PASS2: state_next = DONE;
            DONE: begin
                resp_valid = 1'b1;
                if (resp_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            pri         <= 1'b0;
            single_q    <= 1'b0;
            pol_q       <= 1'b0;
            p1_q        <= 1'b0;
            resp_result <= 1'b0;
            resp_id     <= 1'b0;
            resp_err    <= 1'b0;
            cmp_m       <= 32'd0;
            cmp_n       <= 32'd0;
            cmp_equal   <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (accept) begin
                        pri         <= ~sel_id;
                        single_q    <= sel_op[2];
                        pol_q       <= sel_op[0];
                        resp_id     <= sel_id;
                        resp_result <= 1'b0;
                        resp_err    <= !sel_legal;
                        if (sel_legal) begin
                            cmp_m     <= xa;
                            cmp_n     <= xb;
                            cmp_equal <= 1'b1;
                        end
                    end
                end
                PASS1: begin
                    p1_q <= cmp_result;
                    // GE/GEU keep the A>=B outcome, LT/LTU invert it; EQ/NE swap for B>=A.
                    if (single_q) begin
                        resp_result <= pol_q ? cmp_result : !cmp_result;
                    end else begin
                        cmp_m <= cmp_n;
                        cmp_n <= cmp_m;
                    end
                end
                PASS2: resp_result <= pol_q ? !(p1_q && cmp_result) : (p1_q && cmp_result);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cmp_scheduler.sv
// Directed bench for cmp_scheduler with a behavioural comparator and a scoreboard
// of expected responses computed from RV32I compare semantics.
module tb_cmp_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0]  req0_op, req1_op;
    logic        resp_valid, resp_ready, resp_result, resp_id, resp_err;
    logic [31:0] cmp_m, cmp_n;
    logic        cmp_equal, cmp_result;

    typedef struct packed {
        logic id;
        logic result;
        logic err;
    } exp_t;

    exp_t        sb[$];
    int          passed = 0;
    int          failed = 0;
    int          total  = 0;
    int          cyc    = 0;
    int          acc_cyc, hs_cyc, prev_hs;
    logic [31:0] p1m, p1n, p2m, p2n;
    logic        p1e;

    cmp_scheduler dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_result(resp_result), .resp_id(resp_id), .resp_err(resp_err),
        .cmp_m(cmp_m), .cmp_n(cmp_n), .cmp_equal(cmp_equal),
        .cmp_result(cmp_result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Ideal comparator: m > n, or m >= n when the tie input is set.
    assign cmp_result = cmp_equal ? (cmp_m >= cmp_n) : (cmp_m > cmp_n);

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic id, input logic [31:0] a, input logic [31:0] b,
                                   input logic [2:0] op);
        exp_t e;
        e.id  = id;
        e.err = 1'b0;
        case (op)
            3'b000:  e.result = (a == b);
            3'b001:  e.result = (a != b);
            3'b100:  e.result = ($signed(a) <  $signed(b));
            3'b101:  e.result = ($signed(a) >= $signed(b));
            3'b110:  e.result = (a <  b);
            3'b111:  e.result = (a >= b);
            default: begin e.result = 1'b0; e.err = 1'b1; end
        endcase
        return e;
    endfunction

    task automatic check_response(input string tag);
        exp_t e;
        check_output({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check_output({tag, "_id"},     32'(resp_id),     32'(e.id));
            check_output({tag, "_result"}, 32'(resp_result), 32'(e.result));
            check_output({tag, "_err"},    32'(resp_err),    32'(e.err));
        end
    endtask

    // One request on one port; hold>0 stalls resp_ready and raises port 1 during the stall.
    task automatic apply_stimulus(input logic port, input logic [31:0] a, input logic [31:0] b,
                                  input logic [2:0] op, input int lat, input int hold,
                                  input string tag);
        bit   got;
        exp_t e;
        if (port) begin
            req1_a = a; req1_b = b; req1_op = op; req1_valid = 1'b1;
        end else begin
            req0_a = a; req0_b = b; req0_op = op; req0_valid = 1'b1;
        end
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (port ? req1_ready : req0_ready) begin
                got = 1'b1;
                acc_cyc = cyc;
                sb.push_back(model(port, a, b, op));
            end
            @(posedge clk); #1;
        end
        if (port) req1_valid = 1'b0; else req0_valid = 1'b0;
        check_output({tag, "_accept"}, 32'(got), 32'd1);
        if (!got) return;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (cyc == acc_cyc + 1) begin p1m = cmp_m; p1n = cmp_n; p1e = cmp_equal; end
            if (cyc == acc_cyc + 2) begin p2m = cmp_m; p2n = cmp_n; end
            if (resp_valid) begin
                got = 1'b1;
                check_output({tag, "_latency"}, 32'(cyc - acc_cyc), 32'(lat));
                if (hold > 0) begin
                    resp_ready = 1'b0;
                    req1_valid = 1'b1;
                    e = sb[0];
                    for (int h = 0; h < hold; h++) begin
                        @(posedge clk);
                        @(negedge clk);
                        check_output({tag, "_hold_valid"},  32'(resp_valid),  32'd1);
                        check_output({tag, "_hold_result"}, 32'(resp_result), 32'(e.result));
                        check_output({tag, "_hold_id"},     32'(resp_id),     32'(e.id));
                        check_output({tag, "_hold_rdy0"},   32'(req0_ready),  32'd0);
                        check_output({tag, "_hold_rdy1"},   32'(req1_ready),  32'd0);
                    end
                    resp_ready = 1'b1;
                end
                hs_cyc = cyc;
                check_response(tag);
            end
            @(posedge clk); #1;
        end
        check_output({tag, "_resp"}, 32'(got), 32'd1);
    endtask

    initial begin
        int   grants[4];
        int   n_grant, n_resp;
        bit   chg0, chg1, got, seen_rv;

        rst = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0; resp_ready = 1'b1;
        req0_a = '0; req0_b = '0; req0_op = '0;
        req1_a = '0; req1_b = '0; req1_op = '0;
        @(posedge clk); @(posedge clk); #1;
        check_output("rst_resp_valid", 32'(resp_valid), 32'd0);
        check_output("rst_cmp_m",      cmp_m,            32'd0);
        check_output("rst_cmp_equal",  32'(cmp_equal),  32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        $display("[TB] signed and unsigned compares");
        apply_stimulus(1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 3'b100, 2, 0, "lt");
        check_output("lt_p1_m",     p1m,        32'h7FFF_FFFF);
        check_output("lt_p1_n",     p1n,        32'h8000_0001);
        check_output("lt_p1_equal", 32'(p1e),   32'd1);
        apply_stimulus(1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 3'b110, 2, 0, "ltu");
        apply_stimulus(1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 3'b111, 2, 0, "geu");
        apply_stimulus(1'b0, 32'h8000_0000, 32'h8000_0000, 3'b101, 2, 0, "ge_eq");
        apply_stimulus(1'b1, 32'h0000_0010, 32'hFFFF_FFF0, 3'b101, 2, 0, "ge_neg");

        $display("[TB] equality");
        apply_stimulus(1'b0, 32'h1234_5678, 32'h1234_5678, 3'b000, 3, 0, "eq_same");
        apply_stimulus(1'b1, 32'd5, 32'd6, 3'b001, 3, 0, "ne");
        apply_stimulus(1'b0, 32'd5, 32'd6, 3'b000, 3, 0, "eq_diff");
        check_output("eq_p1_m", p1m, 32'd5);
        check_output("eq_p1_n", p1n, 32'd6);
        check_output("eq_p2_m", p2m, 32'd6);
        check_output("eq_p2_n", p2n, 32'd5);

        $display("[TB] backpressure");
        req1_a = 32'd3; req1_b = 32'd9; req1_op = 3'b110;
        apply_stimulus(1'b0, 32'd7, 32'd2, 3'b111, 2, 4, "bp");
        prev_hs = hs_cyc;
        apply_stimulus(1'b1, 32'd3, 32'd9, 3'b110, 2, 0, "bp_next");
        check_output("bp_accept_cycle", 32'(acc_cyc), 32'(prev_hs + 1));

        $display("[TB] round-robin arbitration");
        n_grant = 0; n_resp = 0; chg0 = 1'b0; chg1 = 1'b0;
        req0_a = $urandom; req0_b = $urandom; req0_op = 3'b110; req0_valid = 1'b1;
        req1_a = $urandom; req1_b = $urandom; req1_op = 3'b110; req1_valid = 1'b1;
        for (int i = 0; i < 60 && n_resp < 4; i++) begin
            @(negedge clk);
            check_output("arb_one_ready", 32'(req0_ready && req1_ready), 32'd0);
            if (resp_valid) begin
                check_response("arb");
                n_resp++;
            end
            if (req0_ready && n_grant < 4) begin
                grants[n_grant] = 0; n_grant++; chg0 = 1'b1;
                sb.push_back(model(1'b0, req0_a, req0_b, req0_op));
            end
            if (req1_ready && n_grant < 4) begin
                grants[n_grant] = 1; n_grant++; chg1 = 1'b1;
                sb.push_back(model(1'b1, req1_a, req1_b, req1_op));
            end
            @(posedge clk); #1;
            if (chg0) begin req0_a = $urandom; req0_b = $urandom; chg0 = 1'b0; end
            if (chg1) begin req1_a = $urandom; req1_b = $urandom; chg1 = 1'b0; end
            if (n_grant >= 4) begin req0_valid = 1'b0; req1_valid = 1'b0; end
        end
        check_output("arb_responses", 32'(n_resp), 32'd4);
        for (int i = 0; i < 4; i++)
            check_output($sformatf("arb_grant%0d", i), 32'(grants[i]), 32'(i % 2));

        $display("[TB] single requester back-to-back");
        apply_stimulus(1'b1, 32'd100, 32'd200, 3'b110, 2, 0, "solo1_a");
        prev_hs = hs_cyc;
        apply_stimulus(1'b1, 32'd300, 32'd200, 3'b110, 2, 0, "solo1_b");
        check_output("solo1_back_to_back", 32'(acc_cyc), 32'(prev_hs + 1));

        $display("[TB] reset during second pass");
        req0_a = 32'hAAAA_0000; req0_b = 32'hAAAA_0000; req0_op = 3'b000; req0_valid = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = req0_ready;
            @(posedge clk); #1;
        end
        check_output("rst_eq_accept", 32'(got), 32'd1);
        req0_valid = 1'b0;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check_output("arst_ready0",  32'(req0_ready),  32'd0);
        check_output("arst_ready1",  32'(req1_ready),  32'd0);
        check_output("arst_valid",   32'(resp_valid),  32'd0);
        check_output("arst_result",  32'(resp_result), 32'd0);
        check_output("arst_id",      32'(resp_id),     32'd0);
        check_output("arst_err",     32'(resp_err),    32'd0);
        check_output("arst_cmp_m",   cmp_m,            32'd0);
        check_output("arst_cmp_n",   cmp_n,            32'd0);
        check_output("arst_cmp_eq",  32'(cmp_equal),   32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        seen_rv = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            seen_rv = seen_rv | resp_valid;
        end
        check_output("arst_no_resp", 32'(seen_rv), 32'd0);
        @(posedge clk); #1;

        $display("[TB] illegal op");
        apply_stimulus(1'b0, 32'd1, 32'd2, 3'b010, 1, 0, "illegal");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/cmp_scheduler.md
# cmp_scheduler

Sequencer and two-way arbiter for the shared 32-bit ripple comparator, which computes m > n unsigned, or m >= n when its equal input is high. It accepts compare requests from the branch unit (port 0) and the ALU SLT/SLTU path (port 1) and grants them round-robin. It maps each RV32I compare op onto one or two comparator passes, using sign-bit flipping for signed compares and a swapped second pass for equality. Because of the 32-stage ripple path, the comparator gets a full cycle per pass. The comparator sits outside this block and connects through the cmp_* ports.

## Interface
- No parameters; data width fixed at 32.
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-high
- req0_valid / req1_valid  in  1  request present
- req0_ready / req1_ready  out  1  request accepted this cycle
- req0_a, req0_b / req1_a, req1_b  in  32  operands
- req0_op / req1_op  in  3  funct3: 000 EQ, 001 NE, 100 LT, 101 GE, 110 LTU, 111 GEU
- resp_valid  out  1  result available
- resp_ready  in  1  result consumed
- resp_result  out  1  compare outcome
- resp_id  out  1  requester that owns the result
- resp_err  out  1  op was 010/011 (illegal)
- cmp_m, cmp_n  out  32  comparator operands
- cmp_equal  out  1  comparator tie value (1 selects >=)
- cmp_result  in  1  comparator output

## Operation
- States: IDLE, PASS1, PASS2, DONE.
- IDLE:
  - Arbitration is round-robin. Priority goes to the requester not granted last; after reset, port 0 has priority.
  - readyN = (state==IDLE) && granted N; it is combinational from validN.
  - On accept: register a, b, op, id.
  - Legal op: go to PASS1.
  - Illegal op: go to DONE with result 0 and err=1; no comparator pass.
- Operand transform:
  - Signed ops (LT, GE): register a and b with bit 31 inverted.
  - All other ops: register a and b unchanged.
- PASS1:
  - Drive cmp_m=A, cmp_n=B, cmp_equal=1, giving A>=B.
  - At the clock edge, capture cmp_result into p1.
  - EQ/NE go to PASS2; all other ops go to DONE.
- PASS2:
  - Drive cmp_m=B, cmp_n=A, cmp_equal=1, giving B>=A.
  - Capture p2, then go to DONE.
- Result:
  - GE/GEU: p1.
  - LT/LTU: !p1.
  - EQ: p1&p2.
  - NE: !(p1&p2).
- DONE:
  - resp_valid=1. resp_result, resp_id and resp_err are registered and held stable.
  - On resp_valid&&resp_ready, go to IDLE.
  - No request is accepted while resp_valid is high.
- cmp_* outputs are registered. They hold their last values outside PASS1/PASS2, so the comparator input is stable for the whole pass cycle.
- Requesters must hold valid/operands stable until ready; a dropped valid before grant is allowed and simply not served.

## Timing
- Reset values: req*_ready 0, resp_valid 0, resp_result 0, resp_id 0, resp_err 0, cmp_m 0, cmp_n 0, cmp_equal 0, state IDLE, priority on port 0.
- Reset mid-operation: the transaction is dropped, no response is produced, and outputs take reset values immediately (asynchronous).
- Latency, with accept at edge T:
  - Single-pass ops: resp_valid high from T+2.
  - EQ/NE: resp_valid high from T+3.
  - Illegal ops: resp_valid high from T+1.
- Throughput: one request per 3 cycles (single-pass), 4 cycles (EQ/NE), or 2 cycles (illegal), all with resp_ready held high. No overlap between requests.
- Backpressure: resp_ready low holds DONE indefinitely. Both readies stay 0 while in DONE.
- Simultaneous valid on both ports: only the priority holder gets ready. The other port waits in IDLE and is served next.
- Round-robin pointer updates only on accept. A single requester may be granted back-to-back when the other port is idle.

## Test plan
- Signed LT: port 0, a=0xFFFFFFFF, b=0x00000001, op=100.
  - During PASS1: cmp_m=0x7FFFFFFF, cmp_n=0x80000001, cmp_equal=1.
  - resp_valid at T+2 with result 1, id 0, err 0.
- Unsigned compares on the same operands:
  - op=110 (LTU): result 0.
  - op=111 (GEU): result 1.
  - op=101 (GE) with a=b=0x80000000: result 1.
- Equality:
  - EQ with a=b=0x12345678: two passes (second has cmp_m/cmp_n swapped), result 1 at T+3.
  - NE with a=5, b=6: result 1.
  - EQ with a=5, b=6: result 0.
- Arbitration: both ports valid continuously, all ops LTU, resp_ready=1.
  - Grant order is 0,1,0,1.
  - resp_id matches the grant order and each result matches its operands.
  - Port 1 alone, valid on consecutive requests: consecutive grants to port 1.
- Backpressure: resp_ready held 0 for 4 cycles after resp_valid.
  - resp_valid, resp_result and resp_id stay stable; both readies stay 0.
  - Accept happens in the cycle after the response handshake.
- Reset and illegal op:
  - Assert rst during PASS2 of an EQ: all outputs reach reset values without a clock edge, and no response appears after release.
  - Then send op=010: resp_valid at T+1 with result 0, err 1.
